// File: rtl/femtorv_mem_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port indices and request kinds.
package femtorv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    KIND_READ  = 1'b0,
    KIND_WRITE = 1'b1
  } kind_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection: a lone pending port wins; on a tie the port not granted last wins.
module mem_arb_pick
  import femtorv_mem_pkg::*;
(
  input  logic [1:0] pending,
  input  logic       last_grant,
  output logic [1:0] winner
);

  always_comb begin
    winner = 2'b00;
    case (pending)
      2'b01:   winner = port_onehot(PORT_CPU);
      2'b10:   winner = port_onehot(PORT_AUX);
      2'b11:   winner = port_onehot(~last_grant);
      default: winner = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter onto a single femtorv-style memory port (IDLE -> ISSUE -> WAIT).
// Define MEM_ARBITER_RR_EN for round-robin tie breaking; otherwise m0 has fixed priority.
module mem_arbiter
  import femtorv_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_rstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_rbusy,
  output logic        m0_wbusy,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_rstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_rbusy,
  output logic        m1_wbusy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rbusy,
  input  logic        mem_wbusy,
  output logic [1:0]  grant
);

  state_t      state, state_next;
  logic [1:0]  pend;
  kind_t       kind      [2];
  logic [31:0] lat_addr  [2];
  logic [31:0] lat_wdata [2];
  logic [3:0]  lat_wmask [2];
  logic [31:0] rdata_q   [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wmask [2];
  logic [1:0]  req_hit;
  logic [1:0]  winner;
  logic        win_idx;
  logic        owner;
  logic        start_txn;
  logic        done_txn;
  logic        last_grant;

  assign req_addr[0]  = m0_addr;
  assign req_addr[1]  = m1_addr;
  assign req_wdata[0] = m0_wdata;
  assign req_wdata[1] = m1_wdata;
  assign req_wmask[0] = m0_wmask;
  assign req_wmask[1] = m1_wmask;
  assign req_hit[0]   = m0_rstrb | (|m0_wmask);
  assign req_hit[1]   = m1_rstrb | (|m1_wmask);

  assign m0_rbusy = pend[0] && (kind[0] == KIND_READ);
  assign m0_wbusy = pend[0] && (kind[0] == KIND_WRITE);
  assign m1_rbusy = pend[1] && (kind[1] == KIND_READ);
  assign m1_wbusy = pend[1] && (kind[1] == KIND_WRITE);
  assign m0_rdata = rdata_q[0];
  assign m1_rdata = rdata_q[1];

  mem_arb_pick u_pick (
    .pending    (pend),
    .last_grant (last_grant),
    .winner     (winner)
  );

  assign win_idx = winner[1];

`ifdef MEM_ARBITER_RR_EN
  always_ff @(posedge clk) begin
    if (reset)
      last_grant <= PORT_AUX;
    else if (start_txn)
      last_grant <= win_idx;
  end
`else
  // Pretending m1 was always granted last makes the picker favour m0 on every tie.
  assign last_grant = PORT_AUX;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_txn  = 1'b0;
    done_txn   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|pend) begin
          start_txn  = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if ((kind[owner] == KIND_READ) ? !mem_rbusy : !mem_wbusy) begin
          done_txn   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A write mask wins over a simultaneous read strobe; a busy port ignores new strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (done_txn && (owner == 1'(i)))
          pend[i] <= 1'b0;
        if (req_hit[i] && !pend[i]) begin
          pend[i]      <= 1'b1;
          lat_addr[i]  <= req_addr[i];
          lat_wdata[i] <= req_wdata[i];
          lat_wmask[i] <= req_wmask[i];
          kind[i]      <= (|req_wmask[i]) ? KIND_WRITE : KIND_READ;
        end
      end
    end
  end

  // The strobe registers are set on entry to ISSUE, so they are high only during ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      mem_rstrb  <= 1'b0;
      grant      <= 2'b00;
      owner      <= PORT_CPU;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      mem_rstrb <= 1'b0;
      mem_wmask <= '0;
      if (start_txn) begin
        mem_addr  <= lat_addr[win_idx];
        mem_wdata <= lat_wdata[win_idx];
        grant     <= winner;
        owner     <= win_idx;
        if (kind[win_idx] == KIND_READ)
          mem_rstrb <= 1'b1;
        else
          mem_wmask <= lat_wmask[win_idx];
      end
      if (done_txn) begin
        grant <= 2'b00;
        if (kind[owner] == KIND_READ)
          rdata_q[owner] <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single transactions plus hand-written
// sequences for ties, overlap, reset abort and duplicate strobes.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wmask;
  logic        m0_rstrb, m0_rbusy, m0_wbusy;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wmask;
  logic        m1_rstrb, m1_rbusy, m1_wbusy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb, mem_rbusy, mem_wbusy;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural memory: busy for wait cycles after the strobe edge, data from the strobe edge.
  logic [31:0] rd_value = 32'h0;
  int          rd_wait  = 0;
  int          wr_wait  = 0;
  int          rcnt     = 0;
  int          wcnt     = 0;
  int          rstrb_pulses = 0;
  int          wmask_pulses = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_wmask  (m0_wmask),
    .m0_rstrb  (m0_rstrb),
    .m0_rdata  (m0_rdata),
    .m0_rbusy  (m0_rbusy),
    .m0_wbusy  (m0_wbusy),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_wmask  (m1_wmask),
    .m1_rstrb  (m1_rstrb),
    .m1_rdata  (m1_rdata),
    .m1_rbusy  (m1_rbusy),
    .m1_wbusy  (m1_wbusy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rstrb (mem_rstrb),
    .mem_rdata (mem_rdata),
    .mem_rbusy (mem_rbusy),
    .mem_wbusy (mem_wbusy),
    .grant     (grant)
  );

  always @(posedge clk) begin
    if (reset) begin
      mem_rdata <= 32'h0;
      mem_rbusy <= 1'b0;
      mem_wbusy <= 1'b0;
      rcnt      <= 0;
      wcnt      <= 0;
    end else begin
      if (mem_rstrb) begin
        rstrb_pulses <= rstrb_pulses + 1;
        mem_rdata    <= rd_value;
        if (rd_wait > 0) begin
          mem_rbusy <= 1'b1;
          rcnt      <= rd_wait;
        end
      end else if (rcnt > 0) begin
        rcnt <= rcnt - 1;
        if (rcnt == 1) mem_rbusy <= 1'b0;
      end
      if (mem_wmask != 4'h0) begin
        wmask_pulses <= wmask_pulses + 1;
        if (wr_wait > 0) begin
          mem_wbusy <= 1'b1;
          wcnt      <= wr_wait;
        end
      end else if (wcnt > 0) begin
        wcnt <= wcnt - 1;
        if (wcnt == 1) mem_wbusy <= 1'b0;
      end
    end
  end

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rstrb;
    logic [31:0] mem_val;
    int          wait_cyc;
    logic        exp_read;
    int          exp_done;
    logic [31:0] exp_rd0;
    logic [31:0] exp_rd1;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idleInputs();
    m0_rstrb = 1'b0; m0_wmask = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_rstrb = 1'b0; m1_wmask = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
  endtask

  task automatic setPort(input logic port, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wmask, input logic rstrb);
    if (port) begin
      m1_addr = addr; m1_wdata = wdata; m1_wmask = wmask; m1_rstrb = rstrb;
    end else begin
      m0_addr = addr; m0_wdata = wdata; m0_wmask = wmask; m0_rstrb = rstrb;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    idleInputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Strobe is driven in cycle T (this negedge); cycle k is sampled k negedges later.
  task automatic applyStimulus(input vec_t v);
    int   done_k;
    int   r0, w0;
    logic rb, wb;
    done_k  = -1;
    rd_value = v.mem_val;
    rd_wait  = v.wait_cyc;
    wr_wait  = v.wait_cyc;
    r0 = rstrb_pulses;
    w0 = wmask_pulses;
    setPort(v.port, v.addr, v.wdata, v.wmask, v.rstrb);
    for (int k = 1; k <= 20; k++) begin
      tick();
      rb = v.port ? m1_rbusy : m0_rbusy;
      wb = v.port ? m1_wbusy : m0_wbusy;
      if (k == 1) begin
        idleInputs();
        checkOutput("busy_kind", 32'({rb, wb}), v.exp_read ? 32'd2 : 32'd1);
      end
      if (k == 2) begin
        checkOutput("issue_addr", mem_addr, v.addr);
        checkOutput("issue_grant", 32'(grant), v.port ? 32'd2 : 32'd1);
        checkOutput("issue_rstrb", 32'(mem_rstrb), 32'(v.exp_read));
        checkOutput("issue_wmask", 32'(mem_wmask), v.exp_read ? 32'd0 : 32'(v.wmask));
        if (!v.exp_read) checkOutput("issue_wdata", mem_wdata, v.wdata);
      end
      if (!rb && !wb) begin
        done_k = k;
        break;
      end
    end
    checkOutput("latency", 32'(done_k), 32'(v.exp_done));
    checkOutput("rdata_m0", m0_rdata, v.exp_rd0);
    checkOutput("rdata_m1", m1_rdata, v.exp_rd1);
    checkOutput("grant_idle", 32'(grant), 32'd0);
    checkOutput("rstrb_pulses", 32'(rstrb_pulses - r0), v.exp_read ? 32'd1 : 32'd0);
    checkOutput("wmask_pulses", 32'(wmask_pulses - w0), v.exp_read ? 32'd0 : 32'd1);
  endtask

  task automatic tieRound(input string tag, input logic [31:0] value,
                          input logic [1:0] exp_first, input logic [1:0] exp_last);
    logic [1:0] first, last;
    first    = 2'b00;
    last     = 2'b00;
    rd_wait  = 0;
    rd_value = value;
    setPort(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    setPort(1'b1, 32'h20, 32'h0, 4'h0, 1'b1);
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 1) idleInputs();
      if (grant != 2'b00) begin
        if (first == 2'b00) first = grant;
        last = grant;
      end
      if (!m0_rbusy && !m1_rbusy) break;
    end
    checkOutput({tag, "_first_grant"}, 32'(first), 32'(exp_first));
    checkOutput({tag, "_last_grant"}, 32'(last), 32'(exp_last));
    checkOutput({tag, "_rdata_m0"}, m0_rdata, value);
    checkOutput({tag, "_rdata_m1"}, m1_rdata, value);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] seq [8];
    int         n_seq, done_k, idle_wait, r0, w0;
    logic [1:0] prev;

    vecs[0] = '{1'b0, 32'h100, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 0, 1'b1, 4,
                32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 32'h200, 32'h12345678, 4'hF, 1'b0, 32'h0,        3, 1'b0, 7,
                32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 32'h300, 32'h0,        4'h0, 1'b1, 32'hCAFEF00D, 2, 1'b1, 6,
                32'hDEADBEEF, 32'hCAFEF00D};
    vecs[3] = '{1'b1, 32'h304, 32'hA5A5A5A5, 4'h4, 1'b0, 32'h0,        0, 1'b0, 4,
                32'hDEADBEEF, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 32'h400, 32'h0000BEEF, 4'h3, 1'b1, 32'h77777777, 1, 1'b0, 5,
                32'hDEADBEEF, 32'hCAFEF00D};
    vecs[5] = '{1'b0, 32'h104, 32'h0,        4'h0, 1'b1, 32'h01234567, 1, 1'b1, 5,
                32'h01234567, 32'hCAFEF00D};
    vecs[6] = '{1'b1, 32'h308, 32'h0,        4'h0, 1'b1, 32'h89ABCDEF, 0, 1'b1, 4,
                32'h01234567, 32'h89ABCDEF};

    // Reset with strobes held: outputs cleared and the strobes must not be captured.
    reset = 1'b1;
    idleInputs();
    m0_rstrb = 1'b1;
    m1_wmask = 4'hF;
    m1_addr  = 32'h44;
    tick(); tick(); tick();
    checkOutput("reset_grant", 32'(grant), 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'h0);
    checkOutput("reset_strobes", 32'({mem_wmask, mem_rstrb}), 32'd0);
    checkOutput("reset_busy", 32'({m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy}), 32'd0);
    checkOutput("reset_rdata_m0", m0_rdata, 32'h0);
    checkOutput("reset_rdata_m1", m1_rdata, 32'h0);
    idleInputs();
    reset = 1'b0;
    tick(); tick(); tick();
    checkOutput("reset_strobe_ignored_busy", 32'({m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy}), 32'd0);
    checkOutput("reset_strobe_ignored_grant", 32'(grant), 32'd0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      tick();
      tick();
    end

    // m1 write in flight, m0 read arrives during WAIT: grant 10 -> 00 -> 01.
    wr_wait  = 3;
    rd_wait  = 0;
    rd_value = 32'h5A5A5A5A;
    n_seq     = 0;
    prev      = 2'b11;
    idle_wait = 0;
    done_k    = -1;
    setPort(1'b1, 32'h500, 32'hFEEDFACE, 4'hF, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 1) idleInputs();
      if (k == 3) setPort(1'b0, 32'h108, 32'h0, 4'h0, 1'b1);
      if (k == 4) begin
        idleInputs();
        checkOutput("overlap_m0_held", 32'(m0_rbusy), 32'd1);
      end
      if (grant != prev && n_seq < 8) begin
        seq[n_seq] = grant;
        n_seq++;
        prev = grant;
      end
      if (grant == 2'b00 && m0_rbusy) idle_wait++;
      if (k >= 4 && !m0_rbusy && !m1_wbusy) begin
        done_k = k;
        break;
      end
    end
    checkOutput("overlap_seq_len", 32'(n_seq), 32'd5);
    checkOutput("overlap_seq1", 32'(seq[1]), 32'd2);
    checkOutput("overlap_seq2", 32'(seq[2]), 32'd0);
    checkOutput("overlap_seq3", 32'(seq[3]), 32'd1);
    checkOutput("overlap_idle_gap", 32'(idle_wait), 32'd1);
    checkOutput("overlap_m0_done", 32'(done_k), 32'd10);
    checkOutput("overlap_m0_rdata", m0_rdata, 32'h5A5A5A5A);
    tick();

    // Read strobe together with a mask is a write; a second strobe while pending is dropped.
    wr_wait = 2;
    done_k  = -1;
    r0 = rstrb_pulses;
    w0 = wmask_pulses;
    setPort(1'b0, 32'h600, 32'hC0FFEE00, 4'h3, 1'b1);
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 1) begin
        idleInputs();
        checkOutput("dup_kind", 32'({m0_rbusy, m0_wbusy}), 32'd1);
      end
      if (k == 2) begin
        checkOutput("dup_issue_wmask", 32'(mem_wmask), 32'h3);
        checkOutput("dup_issue_rstrb", 32'(mem_rstrb), 32'd0);
        setPort(1'b0, 32'h999, 32'h0, 4'h0, 1'b1);
      end
      if (k == 3) idleInputs();
      if (!m0_rbusy && !m0_wbusy) begin
        done_k = k;
        break;
      end
    end
    checkOutput("dup_done", 32'(done_k), 32'd6);
    for (int k = 0; k < 6; k++) tick();
    checkOutput("dup_no_second_txn", 32'({m0_rbusy, m0_wbusy, grant}), 32'd0);
    checkOutput("dup_rstrb_pulses", 32'(rstrb_pulses - r0), 32'd0);
    checkOutput("dup_wmask_pulses", 32'(wmask_pulses - w0), 32'd1);

    // Simultaneous requests right after reset, then again.
    doReset();
`ifdef MEM_ARBITER_RR_EN
    tieRound("tie1", 32'h11110000, 2'b01, 2'b10);
    tick();
    tieRound("tie2", 32'h22220000, 2'b10, 2'b01);
`else
    tieRound("tie1", 32'h11110000, 2'b01, 2'b10);
    tick();
    tieRound("tie2", 32'h22220000, 2'b01, 2'b10);
`endif
    tick();

    // Reset in WAIT while memory is still busy abandons the read.
    doReset();
    rd_wait  = 5;
    rd_value = 32'hBADC0DE5;
    r0 = rstrb_pulses;
    setPort(1'b0, 32'h10C, 32'h0, 4'h0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) idleInputs();
    end
    checkOutput("abort_in_wait", 32'({mem_rbusy, grant}), 32'b101);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abort_busy", 32'({m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy}), 32'd0);
    checkOutput("abort_grant", 32'(grant), 32'd0);
    checkOutput("abort_rdata", m0_rdata, 32'h0);
    for (int k = 0; k < 8; k++) tick();
    checkOutput("abort_rdata_later", m0_rdata, 32'h0);
    checkOutput("abort_grant_later", 32'(grant), 32'd0);
    checkOutput("abort_no_reissue", 32'(rstrb_pulses - r0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
